// File: rtl/dma_ch_memory_map.sv
// -----------------------------------------------------------------------------
// dma_ch_memory_map
//   MMIO register file for NUM_CH DMA loopback channels. Each channel owns a
//   16-word window starting at BASE_ADDR + 16*c holding its read/write
//   addresses, transfer size, a GO strobe, a sticky status word, a transfer
//   cycle counter and a CLEAR strobe. A small IDLE/BUSY/DONE machine per
//   channel drives a one-cycle go pulse and watches the engine's done level.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   i_mmio_wr_en       MMIO write strobe
//   i_mmio_wr_addr     MMIO write word address [15:0]
//   i_mmio_wr_data     MMIO write data [63:0]
//   i_mmio_rd_en       MMIO read strobe
//   i_mmio_rd_addr     MMIO read word address [15:0]
//   o_mmio_rd_data     registered read data, held between reads
//   o_rd_addr          per-channel read address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   o_wr_addr          per-channel write address
//   o_size             per-channel cache-line count
//   o_go               per-channel one-cycle start pulse
//   i_done             per-channel level done from the DMA engines
// -----------------------------------------------------------------------------
module dma_ch_memory_map #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = 17,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0050
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_mmio_wr_en,
  input  logic [15:0]                  i_mmio_wr_addr,
  input  logic [63:0]                  i_mmio_wr_data,
  input  logic                         i_mmio_rd_en,
  input  logic [15:0]                  i_mmio_rd_addr,
  output logic [63:0]                  o_mmio_rd_data,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_rd_addr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_wr_addr,
  output logic [NUM_CH*SIZE_WIDTH-1:0] o_size,
  output logic [NUM_CH-1:0]            o_go,
  input  logic [NUM_CH-1:0]            i_done
);

  // Total address span of all channel windows, in words.
  localparam logic [16:0] SPAN = 17'(16 * NUM_CH);

  localparam logic [3:0] OFF_GO      = 4'h0;
  localparam logic [3:0] OFF_RD_ADDR = 4'h2;
  localparam logic [3:0] OFF_WR_ADDR = 4'h4;
  localparam logic [3:0] OFF_SIZE    = 4'h6;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_CYCLES  = 4'hA;
  localparam logic [3:0] OFF_CLEAR   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state   [NUM_CH];
  logic [ADDR_WIDTH-1:0] r_rd_addr [NUM_CH];
  logic [ADDR_WIDTH-1:0] r_wr_addr [NUM_CH];
  logic [SIZE_WIDTH-1:0] r_size    [NUM_CH];
  logic [CNT_WIDTH-1:0]  r_cycles  [NUM_CH];
  // Counts down the cycles in which a done level left over from the previous
  // transfer must not be taken as completion of the new one.
  logic [1:0]            r_mask    [NUM_CH];
  logic [NUM_CH-1:0]     r_go;
  logic [NUM_CH-1:0]     r_done_st;
  logic [NUM_CH-1:0]     r_err;
  logic [63:0]           r_rd_data;

  logic [16:0]           w_wr_rel;
  logic [16:0]           w_rd_rel;
  logic                  w_wr_hit;
  logic                  w_rd_hit;
  logic [NUM_CH-1:0]     w_wr_sel;
  logic [NUM_CH-1:0]     w_rd_sel;
  logic [NUM_CH-1:0]     w_done_evt;
  logic [63:0]           w_rd_val;

  // Readable register of one channel at a given offset, zero-extended.
  function automatic logic [63:0] reg_word(
    input logic [3:0]            off,
    input logic [ADDR_WIDTH-1:0] rda,
    input logic [ADDR_WIDTH-1:0] wra,
    input logic [SIZE_WIDTH-1:0] sz,
    input logic [2:0]            status,
    input logic [CNT_WIDTH-1:0]  cyc
  );
    logic [63:0] v;
    case (off)
      OFF_RD_ADDR: v = 64'(rda);
      OFF_WR_ADDR: v = 64'(wra);
      OFF_SIZE:    v = 64'(sz);
      OFF_STATUS:  v = {61'h0, status};
      OFF_CYCLES:  v = 64'(cyc);
      default:     v = 64'h0;
    endcase
    return v;
  endfunction

  // Address decode for both MMIO ports, done qualification and read mux.
  always_comb begin
    // Subtracting in 17 bits makes addresses below the base wrap to a huge
    // value, so one compare against SPAN covers both range limits.
    w_wr_rel   = 17'(i_mmio_wr_addr) - 17'(BASE_ADDR);
    w_rd_rel   = 17'(i_mmio_rd_addr) - 17'(BASE_ADDR);
    w_wr_hit   = i_mmio_wr_en && (w_wr_rel < SPAN) && !i_mmio_wr_addr[0];
    w_rd_hit   = (w_rd_rel < SPAN) && !i_mmio_rd_addr[0];
    w_wr_sel   = {NUM_CH{1'b0}};
    w_rd_sel   = {NUM_CH{1'b0}};
    w_done_evt = {NUM_CH{1'b0}};
    w_rd_val   = 64'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_wr_sel[c]   = w_wr_hit && (w_wr_rel[16:4] == 13'(c));
      w_rd_sel[c]   = w_rd_hit && (w_rd_rel[16:4] == 13'(c));
      w_done_evt[c] = (r_state[c] == ST_BUSY) && (r_mask[c] == 2'd0) && i_done[c];
      w_rd_val      = w_rd_val | (w_rd_sel[c] ?
                        reg_word(w_rd_rel[3:0], r_rd_addr[c], r_wr_addr[c], r_size[c],
                                 {r_err[c], r_state[c] == ST_BUSY, r_done_st[c]},
                                 r_cycles[c]) : 64'h0);
    end
  end

  // Channel state machines, register writes and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]   <= ST_IDLE;
        r_rd_addr[c] <= {ADDR_WIDTH{1'b0}};
        r_wr_addr[c] <= {ADDR_WIDTH{1'b0}};
        r_size[c]    <= {SIZE_WIDTH{1'b0}};
        r_cycles[c]  <= {CNT_WIDTH{1'b0}};
        r_mask[c]    <= 2'd0;
      end
      r_go      <= {NUM_CH{1'b0}};
      r_done_st <= {NUM_CH{1'b0}};
      r_err     <= {NUM_CH{1'b0}};
      r_rd_data <= 64'h0;
    end else begin
      if (i_mmio_rd_en) begin
        r_rd_data <= w_rd_val;
      end else begin
        r_rd_data <= r_rd_data;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        r_go[c] <= 1'b0;

        // Transfer progress; completion freezes the counter.
        if (r_state[c] == ST_BUSY) begin
          if (r_mask[c] != 2'd0) begin
            r_mask[c] <= r_mask[c] - 2'd1;
          end
          if (w_done_evt[c]) begin
            r_state[c]   <= ST_DONE;
            r_done_st[c] <= 1'b1;
          end else if (r_cycles[c] != {CNT_WIDTH{1'b1}}) begin
            r_cycles[c] <= r_cycles[c] + CNT_WIDTH'(1);
          end
        end

        // MMIO writes; anything that would disturb a running transfer is
        // dropped and flagged in err instead.
        if (w_wr_sel[c]) begin
          case (w_wr_rel[3:0])
            OFF_GO: begin
              if (r_state[c] == ST_BUSY) begin
                r_err[c] <= 1'b1;
              end else if (r_size[c] != {SIZE_WIDTH{1'b0}}) begin
                r_state[c]   <= ST_BUSY;
                r_go[c]      <= 1'b1;
                r_cycles[c]  <= {CNT_WIDTH{1'b0}};
                r_done_st[c] <= 1'b0;
                r_mask[c]    <= 2'd2;
              end else begin
                // Empty transfer completes immediately without a go pulse.
                r_state[c]   <= ST_DONE;
                r_cycles[c]  <= {CNT_WIDTH{1'b0}};
                r_done_st[c] <= 1'b1;
              end
            end
            OFF_RD_ADDR: begin
              if (r_state[c] == ST_BUSY) r_err[c] <= 1'b1;
              else r_rd_addr[c] <= i_mmio_wr_data[ADDR_WIDTH-1:0];
            end
            OFF_WR_ADDR: begin
              if (r_state[c] == ST_BUSY) r_err[c] <= 1'b1;
              else r_wr_addr[c] <= i_mmio_wr_data[ADDR_WIDTH-1:0];
            end
            OFF_SIZE: begin
              if (r_state[c] == ST_BUSY) r_err[c] <= 1'b1;
              else r_size[c] <= i_mmio_wr_data[SIZE_WIDTH-1:0];
            end
            OFF_CLEAR: begin
              if (i_mmio_wr_data[0]) begin
                r_err[c] <= 1'b0;
                // A completion landing on the same edge keeps done_sticky set.
                if (!w_done_evt[c]) r_done_st[c] <= 1'b0;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    o_rd_addr = {(NUM_CH*ADDR_WIDTH){1'b0}};
    o_wr_addr = {(NUM_CH*ADDR_WIDTH){1'b0}};
    o_size    = {(NUM_CH*SIZE_WIDTH){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      o_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = r_rd_addr[c];
      o_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = r_wr_addr[c];
      o_size[c*SIZE_WIDTH +: SIZE_WIDTH]    = r_size[c];
    end
  end

  assign o_go           = r_go;
  assign o_mmio_rd_data = r_rd_data;

endmodule
